mptw_mem_arbiter: RTL

N-channel MEM-protocol arbiter that lets several MPT walkers (load, store, fetch, or more) share one downstream MEM port and therefore a single MEM-to-DCACHE converter and dcache request port. Channel count is a parameter; the block adds the following:
- round-robin arbitration with request locking;
- in-order response routing through an ID FIFO, with multiple requests outstanding;
- a sticky protocol-error flag.

It sits between the `mpt_top` instances and one `mem_to_dcache_converter` inside the memory-protection data interface.

---
 rtl/mptw_mem_arbiter_if.sv | 45 ++++
 rtl/mptw_mem_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mptw_mem_arbiter_if.sv
// MEM-protocol bundle for the MPT walker arbiter: the per-channel request/response
// lanes plus the single shared downstream port.
// The slave modport is the arbiter's view. The master modport is the view of the
// surroundings, which are the walkers and the downstream converter.
interface mptw_mem_arbiter_if #(
    parameter int NUM_CH     = 2,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    // Channel side
    logic [NUM_CH-1:0]                     s_mem_req;
    logic [NUM_CH-1:0]                     s_mem_gnt;
    logic [NUM_CH-1:0][ADDR_WIDTH-1:0]     s_mem_addr;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0]     s_mem_wdata;
    logic [NUM_CH-1:0]                     s_mem_we;
    logic [NUM_CH-1:0][DATA_WIDTH/8-1:0]   s_mem_be;
    logic [NUM_CH-1:0]                     s_mem_valid;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0]     s_mem_rdata;
    logic [NUM_CH-1:0]                     s_mem_error;

    // Downstream side
    logic                                  m_mem_req;
    logic                                  m_mem_gnt;
    logic [ADDR_WIDTH-1:0]                 m_mem_addr;
    logic [DATA_WIDTH-1:0]                 m_mem_wdata;
    logic                                  m_mem_we;
    logic [DATA_WIDTH/8-1:0]               m_mem_be;
    logic                                  m_mem_valid;
    logic [DATA_WIDTH-1:0]                 m_mem_rdata;
    logic                                  m_mem_error;

    modport slave (
        input  s_mem_req, s_mem_addr, s_mem_wdata, s_mem_we, s_mem_be,
        output s_mem_gnt, s_mem_valid, s_mem_rdata, s_mem_error,
        output m_mem_req, m_mem_addr, m_mem_wdata, m_mem_we, m_mem_be,
        input  m_mem_gnt, m_mem_valid, m_mem_rdata, m_mem_error
    );

    modport master (
        output s_mem_req, s_mem_addr, s_mem_wdata, s_mem_we, s_mem_be,
        input  s_mem_gnt, s_mem_valid, s_mem_rdata, s_mem_error,
        input  m_mem_req, m_mem_addr, m_mem_wdata, m_mem_we, m_mem_be,
        output m_mem_gnt, m_mem_valid, m_mem_rdata, m_mem_error
    );
endinterface

// File: rtl/mptw_mem_arbiter.sv
// N-channel MEM arbiter that lets several MPT walkers share one downstream port.
// Arbitration is round-robin. A request that is presented but not yet granted locks
// the arbiter onto its channel. A FIFO of channel IDs routes responses back in order,
// and a sticky flag records any response that arrives with nothing outstanding.
module mptw_mem_arbiter #(
    parameter int NUM_CH          = 2,
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    mptw_mem_arbiter_if.slave   bus,
    output logic                busy_o,
    output logic                protocol_err_o
);
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IDX_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    // Advance a FIFO pointer. Depth need not be a power of two, so the wrap is explicit.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] res;
        if (idx == LAST_IDX) begin
            res = {IDX_W{1'b0}};
        end else begin
            res = idx + IDX_W'(1);
        end
        return res;
    endfunction

    // Registered state
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             lock_q, lock_d;
    logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
    logic [SEL_W-1:0] fifo_q [MAX_OUTSTANDING];
    logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             protocol_err_q, protocol_err_d;

    // Combinational helpers
    logic [SEL_W-1:0] rr_sel_s;
    logic             found_s;
    logic [SEL_W-1:0] cand_s;
    logic [SEL_W-1:0] sel_s;
    logic [SEL_W-1:0] head_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             m_req_s;
    logic             hs_s;
    logic             pop_s;

    // Round-robin search: first requesting channel at or after rr_ptr, wrapping modulo NUM_CH.
    always_comb begin
        rr_sel_s = rr_ptr_q;
        found_s  = 1'b0;
        cand_s   = {SEL_W{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            cand_s = SEL_W'((int'(rr_ptr_q) + i) % NUM_CH);
            if (!found_s && bus.s_mem_req[cand_s]) begin
                rr_sel_s = cand_s;
                found_s  = 1'b1;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // A locked channel holds the port until it is granted. Otherwise the round-robin pick wins.
    // The request is also gated by reset, so the port reads idle while reset is asserted.
    always_comb begin
        if (lock_q) begin
            sel_s = lock_ch_q;
        end else begin
            sel_s = rr_sel_s;
        end
        fifo_full_s  = (count_q == FULL_CNT);
        fifo_empty_s = (count_q == {CNT_W{1'b0}});
        head_s       = fifo_q[rd_ptr_q];
        m_req_s      = rst_ni & bus.s_mem_req[sel_s] & ~fifo_full_s;
        hs_s         = m_req_s & bus.m_mem_gnt;
        pop_s        = bus.m_mem_valid & ~fifo_empty_s;
    end

    // Forward the selected request downstream. Route grants and responses back with no added latency.
    always_comb begin
        bus.m_mem_req   = m_req_s;
        bus.m_mem_addr  = bus.s_mem_addr[sel_s];
        bus.m_mem_wdata = bus.s_mem_wdata[sel_s];
        bus.m_mem_we    = bus.s_mem_we[sel_s];
        bus.m_mem_be    = bus.s_mem_be[sel_s];
        bus.s_mem_rdata = {NUM_CH{bus.m_mem_rdata}};
        bus.s_mem_gnt   = {NUM_CH{1'b0}};
        bus.s_mem_valid = {NUM_CH{1'b0}};
        bus.s_mem_error = {NUM_CH{1'b0}};
        if (hs_s) begin
            bus.s_mem_gnt[sel_s] = 1'b1;
        end else begin
            bus.s_mem_gnt = {NUM_CH{1'b0}};
        end
        if (pop_s) begin
            bus.s_mem_valid[head_s] = 1'b1;
            bus.s_mem_error[head_s] = bus.m_mem_error;
        end else begin
            bus.s_mem_valid = {NUM_CH{1'b0}};
            bus.s_mem_error = {NUM_CH{1'b0}};
        end
    end

    // Next-state for the rotation pointer, the lock, the FIFO pointers, the count and the sticky error.
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        lock_d    = lock_q;
        lock_ch_d = lock_ch_q;
        if (hs_s) begin
            rr_ptr_d = (sel_s == LAST_CH) ? {SEL_W{1'b0}} : (sel_s + SEL_W'(1));
            lock_d   = 1'b0;
        end else if (m_req_s) begin
            lock_d    = 1'b1;
            lock_ch_d = sel_s;
        end else begin
            lock_d    = lock_q;
        end

        wr_ptr_d = hs_s  ? next_idx(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_s ? next_idx(rd_ptr_q) : rd_ptr_q;

        case ({hs_s, pop_s})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase

        protocol_err_d = protocol_err_q | (bus.m_mem_valid & fifo_empty_s);
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q       <= {SEL_W{1'b0}};
            lock_q         <= 1'b0;
            lock_ch_q      <= {SEL_W{1'b0}};
            wr_ptr_q       <= {IDX_W{1'b0}};
            rd_ptr_q       <= {IDX_W{1'b0}};
            count_q        <= {CNT_W{1'b0}};
            protocol_err_q <= 1'b0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            lock_q         <= lock_d;
            lock_ch_q      <= lock_ch_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    // ID FIFO storage: the granted channel index is written at the tail on every handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < MAX_OUTSTANDING; k++) begin
                fifo_q[k] <= {SEL_W{1'b0}};
            end
        end else if (hs_s) begin
            fifo_q[wr_ptr_q] <= sel_s;
        end else begin
            fifo_q[wr_ptr_q] <= fifo_q[wr_ptr_q];
        end
    end

    assign busy_o         = ~fifo_empty_s;
    assign protocol_err_o = protocol_err_q;

endmodule
